// File: rtl/mem_arbiter.sv
// Arbitrates the single memory-controller port between I-cache (p0) and D-cache (p1).
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority p1 over p0.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4,
    parameter int RW_W   = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [RW_W-1:0]   p0_rw_flag,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_write_data,
    input  logic [MASK_W-1:0] p0_write_mask,
    output logic [DATA_W-1:0] p0_read_data,
    output logic              p0_busy,
    output logic              p0_done,

    input  logic [RW_W-1:0]   p1_rw_flag,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_write_data,
    input  logic [MASK_W-1:0] p1_write_mask,
    output logic [DATA_W-1:0] p1_read_data,
    output logic              p1_busy,
    output logic              p1_done,

    output logic [RW_W-1:0]   rw_flag,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    output logic [MASK_W-1:0] write_mask,
    input  logic [DATA_W-1:0] read_data,
    input  logic              busy,
    input  logic              done
);

    localparam logic [RW_W-1:0] RW_IDLE  = RW_W'(0);
    localparam logic [RW_W-1:0] RW_READ  = RW_W'(1);
    localparam logic [RW_W-1:0] RW_WRITE = RW_W'(2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RELEASE
    } state_t;

    state_t state, state_nxt;

    logic grant, grant_nxt;
    logic last_grant, last_grant_nxt;

    logic [RW_W-1:0]   rw_flag_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] write_data_nxt;
    logic [MASK_W-1:0] write_mask_nxt;
    logic [DATA_W-1:0] p0_read_data_nxt;
    logic [DATA_W-1:0] p1_read_data_nxt;
    logic              p0_done_nxt;
    logic              p1_done_nxt;

    logic p0_req, p1_req, any_req;
    logic winner, issue;

    // 2'b11 is reserved and behaves exactly like idle
    assign p0_req  = (p0_rw_flag == RW_READ) || (p0_rw_flag == RW_WRITE);
    assign p1_req  = (p1_rw_flag == RW_READ) || (p1_rw_flag == RW_WRITE);
    assign any_req = p0_req || p1_req;

    always_comb begin
        winner = p1_req;
`ifdef MEM_ARB_RR_EN
        if (p0_req && p1_req) begin
            winner = ~last_grant;
        end
`endif
    end

    assign issue = (state == IDLE) && !busy && any_req;

    assign p0_busy = (state != IDLE) || busy || (any_req && winner);
    assign p1_busy = (state != IDLE) || busy || (any_req && !winner);

    always_comb begin
        state_nxt        = state;
        grant_nxt        = grant;
        last_grant_nxt   = last_grant;
        rw_flag_nxt      = rw_flag;
        addr_nxt         = addr;
        write_data_nxt   = write_data;
        write_mask_nxt   = write_mask;
        p0_read_data_nxt = p0_read_data;
        p1_read_data_nxt = p1_read_data;
        p0_done_nxt      = 1'b0;
        p1_done_nxt      = 1'b0;

        unique case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = WAIT;
                    grant_nxt = winner;
                    if (winner) begin
                        rw_flag_nxt    = p1_rw_flag;
                        addr_nxt       = p1_addr;
                        write_data_nxt = p1_write_data;
                        write_mask_nxt = p1_write_mask;
                    end else begin
                        rw_flag_nxt    = p0_rw_flag;
                        addr_nxt       = p0_addr;
                        write_data_nxt = p0_write_data;
                        write_mask_nxt = p0_write_mask;
                    end
                end
            end
            WAIT: begin
                if (done) begin
                    state_nxt      = RELEASE;
                    rw_flag_nxt    = RW_IDLE;
                    last_grant_nxt = grant;
                    if (grant) begin
                        p1_done_nxt = 1'b1;
                        if (rw_flag == RW_READ) begin
                            p1_read_data_nxt = read_data;
                        end
                    end else begin
                        p0_done_nxt = 1'b1;
                        if (rw_flag == RW_READ) begin
                            p0_read_data_nxt = read_data;
                        end
                    end
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            rw_flag      <= RW_IDLE;
            addr         <= '0;
            write_data   <= '0;
            write_mask   <= '0;
            p0_read_data <= '0;
            p1_read_data <= '0;
            p0_done      <= 1'b0;
            p1_done      <= 1'b0;
        end else begin
            state        <= state_nxt;
            grant        <= grant_nxt;
            last_grant   <= last_grant_nxt;
            rw_flag      <= rw_flag_nxt;
            addr         <= addr_nxt;
            write_data   <= write_data_nxt;
            write_mask   <= write_mask_nxt;
            p0_read_data <= p0_read_data_nxt;
            p1_read_data <= p1_read_data_nxt;
            p0_done      <= p0_done_nxt;
            p1_done      <= p1_done_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed corner cases, then random traffic
// against a word-memory reference model and a rule-level arbitration model.
module tb_mem_arbiter;

    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WR = 2'b10;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  p0_rw_flag, p1_rw_flag;
    logic [31:0] p0_addr, p1_addr;
    logic [31:0] p0_write_data, p1_write_data;
    logic [3:0]  p0_write_mask, p1_write_mask;
    logic [31:0] p0_read_data, p1_read_data;
    logic        p0_busy, p1_busy, p0_done, p1_done;
    logic [1:0]  rw_flag;
    logic [31:0] addr, write_data;
    logic [3:0]  write_mask;
    logic [31:0] read_data;
    logic        busy, done;

    logic        mem_en;
    logic        mem_done, mem_busy, mem_act;
    logic [31:0] mem_rdata;
    int          mem_cnt;
    logic        dir_done, dir_busy;
    logic [31:0] dir_rdata;

    assign done      = mem_en ? mem_done  : dir_done;
    assign busy      = mem_en ? mem_busy  : dir_busy;
    assign read_data = mem_en ? mem_rdata : dir_rdata;

    int errors = 0;
    int checks = 0;

    exp_t        exq0[$];
    exp_t        exq1[$];
    bit          grant_log[$];
    logic [31:0] lastrd[2];
    bit [31:0]   mem[bit [31:0]];
    bit [31:0]   sh[bit [31:0]];

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_rw_flag(p0_rw_flag), .p0_addr(p0_addr),
        .p0_write_data(p0_write_data), .p0_write_mask(p0_write_mask),
        .p0_read_data(p0_read_data), .p0_busy(p0_busy), .p0_done(p0_done),
        .p1_rw_flag(p1_rw_flag), .p1_addr(p1_addr),
        .p1_write_data(p1_write_data), .p1_write_mask(p1_write_mask),
        .p1_read_data(p1_read_data), .p1_busy(p1_busy), .p1_done(p1_done),
        .rw_flag(rw_flag), .addr(addr), .write_data(write_data),
        .write_mask(write_mask), .read_data(read_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not reach its end");
        $fatal(1);
    end

    function automatic bit [31:0] init_val(input bit [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d,
                                        input bit [3:0] m);
        bit [31:0] v = old;
        for (int b = 0; b < 4; b++) if (m[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen where none was expected or required event missing", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural memory controller: accepts an issued request, answers after 1..4 cycles.
    initial begin : responder
        mem_done = 0; mem_busy = 0; mem_act = 0; mem_rdata = 0; mem_cnt = 0;
        forever begin
            tick();
            if (!mem_en) begin
                mem_done = 0; mem_busy = 0; mem_act = 0;
            end else begin
                mem_done = 0;
                if (mem_act) begin
                    if (mem_cnt == 0) begin
                        mem_done = 1; mem_act = 0; mem_busy = 0;
                        if (rw_flag == RD) begin
                            mem_rdata = mem.exists(addr) ? mem[addr] : init_val(addr);
                        end else begin
                            mem[addr] = merge(mem.exists(addr) ? mem[addr] : init_val(addr),
                                              write_data, write_mask);
                            mem_rdata = $urandom;
                        end
                    end else mem_cnt--;
                end else if (rw_flag == RD || rw_flag == WR) begin
                    mem_act = 1; mem_busy = 1; mem_cnt = $urandom_range(0, 3);
                end else begin
                    mem_busy = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // Monitor: done/scoreboard pops, arbitration rule at each issue, hold and spacing.
    int          cyc = 0;
    int          pdone_cyc = -100;
    bit          last_srv = 1;
    logic [1:0]  prev_rw = 0, pv0 = 0, pv1 = 0;
    logic [31:0] prev_addr = 0, pa0 = 0, pa1 = 0, pd0 = 0, pd1 = 0;
    logic [3:0]  pm0 = 0, pm1 = 0;
    logic        pbusy = 0, prst = 1;
    bit          mr0, mr1, mw;
    exp_t        me;

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                last_srv = 1;
            end else begin
                chk("single_done_per_cycle", 32'(p0_done & p1_done), 0);
                if (p0_done) begin
                    pdone_cyc = cyc;
                    if (exq0.size() == 0) flag_fail("p0_unexpected_done");
                    else begin
                        me = exq0.pop_front();
                        chk("p0_read_data", p0_read_data, me.data);
                    end
                end
                if (p1_done) begin
                    pdone_cyc = cyc;
                    if (exq1.size() == 0) flag_fail("p1_unexpected_done");
                    else begin
                        me = exq1.pop_front();
                        chk("p1_read_data", p1_read_data, me.data);
                    end
                end
                if (prev_rw == 0 && rw_flag != 0 && !prst) begin
                    mr0 = (pv0 == RD || pv0 == WR);
                    mr1 = (pv1 == RD || pv1 == WR);
                    if (!mr0 && !mr1) flag_fail("issue_without_request");
                    else begin
                        mw = (mr0 && mr1) ? (RR ? !last_srv : 1'b1) : mr1;
                        grant_log.push_back(mw);
                        chk("issue_rw_flag", rw_flag, mw ? pv1 : pv0);
                        chk("issue_addr", addr, mw ? pa1 : pa0);
                        chk("issue_wdata", write_data, mw ? pd1 : pd0);
                        chk("issue_wmask", write_mask, mw ? pm1 : pm0);
                        chk("issue_busy_low", pbusy, 0);
                        chk("issue_spacing", 32'(cyc - pdone_cyc >= 2), 1);
                        last_srv = mw;
                    end
                end
                if (prev_rw != 0 && rw_flag != 0) chk("hold_addr", addr, prev_addr);
            end
            prev_rw = rw_flag; prev_addr = addr;
            pv0 = p0_rw_flag; pa0 = p0_addr; pd0 = p0_write_data; pm0 = p0_write_mask;
            pv1 = p1_rw_flag; pa1 = p1_addr; pd1 = p1_write_data; pm1 = p1_write_mask;
            pbusy = busy; prst = rst;
        end
    end

    task automatic push_exp(input int p, input logic rd, input logic [31:0] d);
        exp_t e;
        e.rd = rd;
        e.data = d;
        if (p == 0) exq0.push_back(e);
        else exq1.push_back(e);
    endtask

    task automatic do_req(input int p, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m);
        logic [31:0] e;
        bit seen = 0;
        if (op == RD) begin
            e = sh.exists(a) ? sh[a] : init_val(a);
            lastrd[p] = e;
        end else begin
            sh[a] = merge(sh.exists(a) ? sh[a] : init_val(a), d, m);
            e = lastrd[p];
        end
        push_exp(p, op == RD, e);
        if (p == 0) begin
            p0_rw_flag = op; p0_addr = a; p0_write_data = d; p0_write_mask = m;
        end else begin
            p1_rw_flag = op; p1_addr = a; p1_write_data = d; p1_write_mask = m;
        end
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            seen = (p == 0) ? p0_done : p1_done;
        end
        if (!seen) flag_fail($sformatf("p%0d_done_timeout", p));
        if (p == 0) p0_rw_flag = 0;
        else p1_rw_flag = 0;
    endtask

    task automatic wait_issue(input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (rw_flag != 0);
        end
        if (!seen) flag_fail(name);
    endtask

    task automatic rand_port(input int p, input int n);
        logic [31:0] base = (p == 0) ? 32'h000 : 32'h200;
        for (int k = 0; k < n; k++) begin
            if (p == 0) p0_rw_flag = $urandom_range(0, 1) ? 2'b11 : 2'b00;
            else p1_rw_flag = $urandom_range(0, 1) ? 2'b11 : 2'b00;
            repeat ($urandom_range(0, 2)) tick();
            do_req(p, $urandom_range(0, 1) ? RD : WR,
                   base + {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                   $urandom, 4'($urandom_range(1, 15)));
        end
    endtask

    initial begin : main
        rst = 1; mem_en = 0;
        dir_done = 0; dir_busy = 0; dir_rdata = 0;
        p0_rw_flag = 0; p0_addr = 0; p0_write_data = 0; p0_write_mask = 0;
        p1_rw_flag = 0; p1_addr = 0; p1_write_data = 0; p1_write_mask = 0;
        lastrd[0] = 0; lastrd[1] = 0;
        repeat (3) tick();
        rst = 0;
        @(negedge clk);
        chk("rst_rw_flag", rw_flag, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_wmask", write_mask, 0);
        chk("rst_p0_rdata", p0_read_data, 0);
        chk("rst_p1_rdata", p1_read_data, 0);
        chk("rst_dones", {p0_done, p1_done}, 0);
        chk("rst_p0_busy", p0_busy, 0);

        // downstream busy then single read
        tick();
        dir_busy = 1; p0_rw_flag = RD; p0_addr = 32'h100;
        lastrd[0] = 32'hDEADBEEF;
        push_exp(0, 1, 32'hDEADBEEF);
        repeat (5) begin
            @(negedge clk);
            chk("busy_rw_idle", rw_flag, 0);
            chk("busy_p0_busy", p0_busy, 1);
        end
        tick();
        dir_busy = 0;
        @(negedge clk);
        chk("busy_drop_rw", rw_flag, 0);
        chk("busy_drop_p0_busy", p0_busy, 0);
        @(negedge clk);
        chk("read_issue_rw", rw_flag, RD);
        chk("read_issue_addr", addr, 32'h100);
        repeat (3) tick();
        dir_done = 1; dir_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("read_p0_done_early", p0_done, 0);
        tick();
        dir_done = 0; dir_rdata = 32'h0BAD0BAD; p0_rw_flag = 0;
        @(negedge clk);
        chk("read_p0_done", p0_done, 1);
        chk("read_p0_rdata", p0_read_data, 32'hDEADBEEF);
        chk("read_p1_rdata", p1_read_data, 0);
        chk("read_p1_done", p1_done, 0);
        @(negedge clk);
        chk("read_p0_done_pulse", p0_done, 0);

        // p1 write
        tick();
        p1_rw_flag = WR; p1_addr = 32'h20;
        p1_write_data = 32'h12345678; p1_write_mask = 4'b0011;
        push_exp(1, 0, lastrd[1]);
        wait_issue("write_issue_timeout");
        chk("write_rw", rw_flag, WR);
        chk("write_wdata", write_data, 32'h12345678);
        chk("write_wmask", write_mask, 4'b0011);
        @(negedge clk);
        chk("write_hold_wdata", write_data, 32'h12345678);
        tick();
        dir_done = 1; dir_rdata = 32'hFFFF0000;
        tick();
        dir_done = 0; p1_rw_flag = 0;
        @(negedge clk);
        chk("write_p1_done", p1_done, 1);
        chk("write_p1_rdata", p1_read_data, 0);
        chk("write_rw_cleared", rw_flag, 0);

        // spurious done in IDLE with reserved flag
        repeat (3) tick();
        p0_rw_flag = 2'b11; dir_done = 1;
        tick();
        dir_done = 0;
        repeat (4) begin
            @(negedge clk);
            chk("spur_rw", rw_flag, 0);
            chk("spur_dones", {p0_done, p1_done}, 0);
        end
        tick();
        p0_rw_flag = 0;

        // reset during WAIT, then a late done
        tick();
        p0_rw_flag = RD; p0_addr = 32'h40;
        wait_issue("rst_issue_timeout");
        chk("rstw_rw_before", rw_flag, RD);
        tick();
        rst = 1; p0_rw_flag = 0;
        exq0.delete(); exq1.delete();
        lastrd[0] = 0; lastrd[1] = 0;
        tick();
        rst = 0;
        @(negedge clk);
        chk("rstw_rw", rw_flag, 0);
        chk("rstw_addr", addr, 0);
        chk("rstw_dones", {p0_done, p1_done}, 0);
        chk("rstw_p0_rdata", p0_read_data, 0);
        tick();
        dir_done = 1;
        tick();
        dir_done = 0;
        repeat (3) begin
            @(negedge clk);
            chk("late_done_dones", {p0_done, p1_done}, 0);
            chk("late_done_rw", rw_flag, 0);
        end

        // contention, then both ports on the same address
        mem_en = 1;
        tick();
        grant_log.delete();
        fork
            do_req(0, RD, 32'h0, 0, 0);
            do_req(1, RD, 32'h4, 0, 0);
        join
        chk("cont_issue_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("cont_first", 32'(grant_log[0]), RR ? 0 : 1);
            chk("cont_second", 32'(grant_log[1]), RR ? 1 : 0);
        end
        grant_log.delete();
        tick();
        fork
            do_req(0, RD, 32'h8, 0, 0);
            do_req(1, RD, 32'h8, 0, 0);
        join
        chk("same_addr_issue_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("same_addr_first", 32'(grant_log[0]), RR ? 0 : 1);
        end

        // randomized concurrent traffic on disjoint regions
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        repeat (5) tick();
        chk("p0_queue_drained", exq0.size(), 0);
        chk("p1_queue_drained", exq1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
